// File: rtl/reg_file_mp.sv
// Multi-ported register file with x0 hardwired to zero, optional write-to-read
// bypass and a per-register busy scoreboard for pending writebacks.
module reg_file_mp #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int BYPASS       = 0,
  localparam int ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_reg,
  output logic [NUM_RD_PORTS*XLEN-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]        rd_busy,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_reg,
  input  logic [XLEN-1:0]                wr_data,
  input  logic                           issue_en,
  input  logic [ADDR_W-1:0]              issue_reg
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic wr_act;
  logic issue_act;

  assign wr_act    = wr_en && (wr_reg != '0);
  assign issue_act = issue_en && (issue_reg != '0);

  // Issue is applied after the write so a same-cycle issue keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_act) begin
      regs_d[wr_reg] = wr_data;
      busy_d[wr_reg] = 1'b0;
    end
    if (issue_act) begin
      busy_d[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;

    assign addr = rd_reg[i*ADDR_W +: ADDR_W];
    // Forwarding is gated by reset so every read port is zero while in reset.
    assign hit  = (BYPASS != 0) && rst_n && wr_en && (wr_reg == addr);

    assign rd_data[i*XLEN +: XLEN] = (addr == '0) ? '0      :
                                     hit          ? wr_data :
                                                    regs_q[addr];

    assign rd_busy[i] = (addr == '0) ? 1'b0 :
                        hit          ? (issue_en && (issue_reg == addr)) :
                                       busy_q[addr];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations driven in lockstep and checked
// every cycle against an array-based model, plus hand-computed spot checks.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr [3];
  logic        wr_en_s;
  logic [4:0]  wr_reg_s;
  logic [63:0] wr_data_s;
  logic        issue_en_s;
  logic [4:0]  issue_reg_s;

  logic [95:0]  rd_data_a;
  logic [2:0]   rd_busy_a;
  logic [63:0]  rd_data_b;
  logic [1:0]   rd_busy_b;
  logic [127:0] rd_data_c;
  logic [1:0]   rd_busy_c;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: 32x32, three ports, no bypass
  reg_file_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(3), .BYPASS(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .rd_reg({rd_addr[2], rd_addr[1], rd_addr[0]}),
    .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en_s), .wr_reg(wr_reg_s), .wr_data(wr_data_s[31:0]),
    .issue_en(issue_en_s), .issue_reg(issue_reg_s)
  );

  // Instance 1: 32x32, two ports, bypass
  reg_file_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd_reg({rd_addr[1], rd_addr[0]}),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en_s), .wr_reg(wr_reg_s), .wr_data(wr_data_s[31:0]),
    .issue_en(issue_en_s), .issue_reg(issue_reg_s)
  );

  // Instance 2: 16x64, two ports, bypass; sees the low four address bits
  reg_file_mp #(.XLEN(64), .NUM_REGS(16), .NUM_RD_PORTS(2), .BYPASS(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .rd_reg({rd_addr[1][3:0], rd_addr[0][3:0]}),
    .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .wr_en(wr_en_s), .wr_reg(wr_reg_s[3:0]), .wr_data(wr_data_s),
    .issue_en(issue_en_s), .issue_reg(issue_reg_s[3:0])
  );

  // Behavioural model: architectural register contents and pending flags per instance
  logic [63:0] m_regs [3][32];
  bit          m_busy [3][32];
  int          m_wa;
  int          m_ia;

  function automatic int nregs_of(input int k);
    return (k == 2) ? 16 : 32;
  endfunction

  function automatic bit byp_of(input int k);
    return (k != 0);
  endfunction

  function automatic logic [63:0] mask_of(input int k);
    return (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++)
        for (int r = 0; r < 32; r++) begin
          m_regs[k][r] = '0;
          m_busy[k][r] = 1'b0;
        end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_wa = int'(wr_reg_s) % nregs_of(k);
        m_ia = int'(issue_reg_s) % nregs_of(k);
        if (wr_en_s && m_wa != 0) begin
          m_regs[k][m_wa] = wr_data_s & mask_of(k);
          m_busy[k][m_wa] = 1'b0;
        end
        if (issue_en_s && m_ia != 0) m_busy[k][m_ia] = 1'b1;
      end
    end
  end

  function automatic logic [63:0] exp_data(input int k, input int a_raw);
    int a;
    a = a_raw % nregs_of(k);
    if (!rst_n || a == 0) return '0;
    if (byp_of(k) && wr_en_s && (int'(wr_reg_s) % nregs_of(k)) == a)
      return wr_data_s & mask_of(k);
    return m_regs[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input int a_raw);
    int a;
    a = a_raw % nregs_of(k);
    if (!rst_n || a == 0) return 1'b0;
    if (byp_of(k) && wr_en_s && (int'(wr_reg_s) % nregs_of(k)) == a)
      return issue_en_s && ((int'(issue_reg_s) % nregs_of(k)) == a);
    return m_busy[k][a];
  endfunction

  task automatic check_port(input int k, input int p, input logic [63:0] act_d, input logic act_b);
    logic [63:0] ed;
    logic        eb;
    ed = exp_data(k, int'(rd_addr[p]));
    eb = exp_busy(k, int'(rd_addr[p]));
    n_cmp++;
    if (act_d !== ed) begin
      n_err++;
      $display("[TB] FAIL rd_data inst%0d port%0d addr%0d: got %h expected %h at %0t",
               k, p, rd_addr[p], act_d, ed, $time);
    end
    n_cmp++;
    if (act_b !== eb) begin
      n_err++;
      $display("[TB] FAIL rd_busy inst%0d port%0d addr%0d: got %b expected %b at %0t",
               k, p, rd_addr[p], act_b, eb, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int p = 0; p < 3; p++) check_port(0, p, {32'h0, rd_data_a[p*32 +: 32]}, rd_busy_a[p]);
      for (int p = 0; p < 2; p++) check_port(1, p, {32'h0, rd_data_b[p*32 +: 32]}, rd_busy_b[p]);
      for (int p = 0; p < 2; p++) check_port(2, p, rd_data_c[p*64 +: 64], rd_busy_c[p]);
    end
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                                input logic ie, input logic [4:0] ir,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    wr_en_s     = we;
    wr_reg_s    = wr;
    wr_data_s   = wd;
    issue_en_s  = ie;
    issue_reg_s = ir;
    rd_addr[0]  = r0;
    rd_addr[1]  = r1;
    rd_addr[2]  = r2;
  endtask

  initial begin
    rst_n       = 1'b0;
    wr_en_s     = 1'b0;
    wr_reg_s    = '0;
    wr_data_s   = '0;
    issue_en_s  = 1'b0;
    issue_reg_s = '0;
    for (int p = 0; p < 3; p++) rd_addr[p] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_on = 1'b1;

    // Preload x5 and mark it busy, then pulse reset between edges
    apply_stimulus(1, 5, 64'hDEAD_BEEF, 1, 5, 5, 5, 5);
    apply_stimulus(0, 0, 0, 0, 0, 5, 5, 5);
    #2;
    check_output("preload x5", {96'h0, rd_data_a[31:0]}, 128'hDEAD_BEEF);
    check_output("preload x5 busy", {125'h0, rd_busy_a}, 128'h7);
    rst_n = 1'b0;
    #1;
    check_output("reset x5 inst0", {32'h0, rd_data_a}, 128'h0);
    check_output("reset busy inst0", {125'h0, rd_busy_a}, 128'h0);
    check_output("reset x5 inst2", rd_data_c, 128'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // x0 is never written and never busy
    apply_stimulus(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_output("x0 data inst0", {32'h0, rd_data_a}, 128'h0);
    check_output("x0 busy inst0", {125'h0, rd_busy_a}, 128'h0);
    check_output("x0 data inst1", {64'h0, rd_data_b}, 128'h0);

    // Write x7 while reading it: old value without bypass, new value with bypass
    apply_stimulus(1, 7, 64'h1234_5678, 0, 0, 7, 7, 7);
    #2;
    check_output("x7 same cycle inst0", {32'h0, rd_data_a}, 128'h0);
    check_output("x7 same cycle inst1 port0", {96'h0, rd_data_b[31:0]}, 128'h1234_5678);
    apply_stimulus(0, 0, 0, 0, 0, 7, 7, 7);
    #2;
    check_output("x7 next cycle inst0", {32'h0, rd_data_a},
                 {32'h0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678});
    for (int r = 1; r < 32; r++) apply_stimulus(0, 0, 0, 0, 0, 5'(r), 5'(r), 5'(r));

    // Bypass on port 1 while port 0 reads an untouched neighbour
    apply_stimulus(1, 9, 64'hA5A5_A5A5, 0, 0, 8, 9, 9);
    #2;
    check_output("bypass x9 inst1", {64'h0, rd_data_b}, {64'h0, 32'hA5A5_A5A5, 32'h0});
    check_output("no bypass x9 inst0 port1", {96'h0, rd_data_a[63:32]}, 128'h0);

    // Scoreboard set, clear, and set-wins on x3
    apply_stimulus(0, 0, 0, 1, 3, 3, 3, 3);
    #2;
    check_output("issue x3 same cycle", {125'h0, rd_busy_a}, 128'h0);
    apply_stimulus(0, 0, 0, 0, 0, 3, 3, 3);
    #2;
    check_output("issue x3 next cycle inst0", {125'h0, rd_busy_a}, 128'h7);
    check_output("issue x3 next cycle inst1", {126'h0, rd_busy_b}, 128'h3);
    apply_stimulus(1, 3, 64'h1111_1111, 0, 0, 3, 3, 3);
    #2;
    check_output("write x3 same cycle inst0", {125'h0, rd_busy_a}, 128'h7);
    check_output("write x3 bypass clear inst1", {126'h0, rd_busy_b}, 128'h0);
    apply_stimulus(0, 0, 0, 0, 0, 3, 3, 3);
    #2;
    check_output("write x3 next cycle", {125'h0, rd_busy_a}, 128'h0);
    apply_stimulus(1, 3, 64'h2222_2222, 1, 3, 3, 3, 3);
    #2;
    check_output("issue+write x3 bypass inst1", {126'h0, rd_busy_b}, 128'h3);
    apply_stimulus(0, 0, 0, 0, 0, 3, 3, 3);
    #2;
    check_output("issue+write x3 busy", {125'h0, rd_busy_a}, 128'h7);
    check_output("issue+write x3 data", {96'h0, rd_data_a[31:0]}, 128'h2222_2222);

    // Wide data on the 16x64 instance
    apply_stimulus(1, 15, 64'h0123_4567_89AB_CDEF, 0, 0, 15, 15, 0);
    #2;
    check_output("x15 bypass inst2", {64'h0, rd_data_c[63:0]}, 128'h0123_4567_89AB_CDEF);
    apply_stimulus(0, 0, 0, 0, 0, 15, 15, 0);
    #2;
    check_output("x15 readback inst2", rd_data_c,
                 {64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF});

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 40; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    // Reset asserted during a write: the write is lost
    apply_stimulus(1, 10, 64'h5555_AAAA, 0, 0, 10, 10, 10);
    #2 rst_n = 1'b0;
    #1;
    check_output("reset mid-write bypass inst1", {64'h0, rd_data_b}, 128'h0);
    wr_en_s = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 10, 10, 10);
    #2;
    check_output("reset mid-write x10 inst0", {32'h0, rd_data_a}, 128'h0);

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
